// File: rtl/rx_ctrl_pkg.sv
// Shared types and sizing helpers for the receiver phase sweep controller.
// Defaults here feed the parameters of the interface, top and accumulator.
package rx_ctrl_pkg;

    localparam int ADC_WIDTH_DEF     = 8;
    localparam int CODE_WIDTH_DEF    = 8;
    localparam int CODE_STEP_DEF     = 4;
    localparam int DWELL_LOG2_DEF    = 4;
    localparam int SETTLE_CYCLES_DEF = 4;

    localparam int METRIC_WIDTH = ADC_WIDTH_DEF + DWELL_LOG2_DEF;
    localparam int N_CODES =
        ((1 << CODE_WIDTH_DEF) - 1) / CODE_STEP_DEF + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACCUM,
        COMPARE,
        APPLY,
        TRACK
    } sweep_state_t;

    function automatic int n_codes(input int cw, input int step);
        return ((1 << cw) - 1) / step + 1;
    endfunction

endpackage

// File: rtl/rx_phase_sweep_ctrl_if.sv
// Control/status bundle between the phase sweep controller and its user.
// slave: controller side (takes start/abort/adc/pd, drives code/status).
interface rx_phase_sweep_ctrl_if
    import rx_ctrl_pkg::*;
#(
    parameter int ADC_WIDTH  = ADC_WIDTH_DEF,
    parameter int CODE_WIDTH = CODE_WIDTH_DEF,
    parameter int DWELL_LOG2 = DWELL_LOG2_DEF
) ();

    logic                              start;
    logic                              abort;
    logic signed [ADC_WIDTH-1:0]       adc_i;
    logic        [1:0]                 pd_adj_i;
    logic        [CODE_WIDTH-1:0]      del_code_o;
    logic                              busy;
    logic                              done;
    logic                              locked;
    logic        [CODE_WIDTH-1:0]      best_code_o;
    logic [ADC_WIDTH+DWELL_LOG2-1:0]   best_metric_o;

    modport master (
        output start, abort, adc_i, pd_adj_i,
        input  del_code_o, busy, done, locked,
        input  best_code_o, best_metric_o
    );

    modport slave (
        input  start, abort, adc_i, pd_adj_i,
        output del_code_o, busy, done, locked,
        output best_code_o, best_metric_o
    );

endinterface

// File: rtl/rx_abs_accum.sv
// Accumulates |adc_i| while en_i is high; clr_i zeroes it (clear wins).
// Ports: clk, rstb (sync, active-low), clr_i, en_i, adc_i (signed), acc_o.
module rx_abs_accum #(
    parameter int ADC_WIDTH    = 8,
    parameter int METRIC_WIDTH = 12
) (
    input  logic                        clk,
    input  logic                        rstb,
    input  logic                        clr_i,
    input  logic                        en_i,
    input  logic signed [ADC_WIDTH-1:0] adc_i,
    output logic [METRIC_WIDTH-1:0]     acc_o
);

    logic [ADC_WIDTH:0]      ext_d;
    logic [ADC_WIDTH:0]      mag_d;
    logic [METRIC_WIDTH-1:0] acc_q;

    // One extra bit so that the most negative sample has a magnitude.
    always_comb begin
        ext_d = {adc_i[ADC_WIDTH-1], adc_i};
        mag_d = ext_d[ADC_WIDTH] ? -ext_d : ext_d;
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + METRIC_WIDTH'(mag_d);
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/rx_phase_sweep_ctrl.sv
// Sweeps the clk_delay code, keeps the code with the largest |adc| sum,
// applies it, then bang-bang tracks from pd_adj_i. Ports: clk, rstb, bus.
module rx_phase_sweep_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int ADC_WIDTH     = ADC_WIDTH_DEF,
    parameter int CODE_WIDTH    = CODE_WIDTH_DEF,
    parameter int CODE_STEP     = CODE_STEP_DEF,
    parameter int DWELL_LOG2    = DWELL_LOG2_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input logic                  clk,
    input logic                  rstb,
    rx_phase_sweep_ctrl_if.slave bus
);

    localparam int MW    = ADC_WIDTH + DWELL_LOG2;
    localparam int CNT_W = DWELL_LOG2 + $clog2(SETTLE_CYCLES + 1) + 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'((1 << DWELL_LOG2) - 1);

    sweep_state_t          state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CODE_WIDTH-1:0] cur_code_q;
    logic [CODE_WIDTH-1:0] del_code_q;
    logic [CODE_WIDTH-1:0] best_code_q;
    logic [MW-1:0]         best_metric_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  locked_q;

    logic [CODE_WIDTH:0]   next_code_d;
    logic [CODE_WIDTH-1:0] trk_code_d;
    logic                  launch_d;
    logic                  acc_clr_d;
    logic                  acc_en_d;
    logic [MW-1:0]         acc;

    // Carry out of the next code means it would pass the top of the range.
    assign next_code_d = {1'b0, cur_code_q} + (CODE_WIDTH+1)'(CODE_STEP);

    assign launch_d  = !bus.abort && bus.start &&
                       (state_q == IDLE || state_q == TRACK);
    assign acc_clr_d = launch_d || (state_q == COMPARE);
    assign acc_en_d  = !bus.abort && (state_q == ACCUM);

    always_comb begin
        trk_code_d = del_code_q;
        unique case (bus.pd_adj_i)
            2'b01: if (del_code_q != '1) trk_code_d = del_code_q + 1'b1;
            2'b11,
            2'b10: if (del_code_q != '0) trk_code_d = del_code_q - 1'b1;
            default: trk_code_d = del_code_q;
        endcase
    end

    rx_abs_accum #(
        .ADC_WIDTH    (ADC_WIDTH),
        .METRIC_WIDTH (MW)
    ) u_accum (
        .clk   (clk),
        .rstb  (rstb),
        .clr_i (acc_clr_d),
        .en_i  (acc_en_d),
        .adc_i (bus.adc_i),
        .acc_o (acc)
    );

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cur_code_q    <= '0;
            del_code_q    <= '0;
            best_code_q   <= '0;
            best_metric_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                // Code and best result are left where they are.
                state_q  <= IDLE;
                cnt_q    <= '0;
                busy_q   <= 1'b0;
                locked_q <= 1'b0;
            end else if (launch_d) begin
                state_q       <= SETTLE;
                cnt_q         <= '0;
                cur_code_q    <= '0;
                del_code_q    <= '0;
                best_code_q   <= '0;
                best_metric_q <= '0;
                busy_q        <= 1'b1;
                locked_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    SETTLE: begin
                        if (cnt_q == SETTLE_LAST) begin
                            cnt_q   <= '0;
                            state_q <= ACCUM;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ACCUM: begin
                        if (cnt_q == DWELL_LAST) begin
                            cnt_q   <= '0;
                            state_q <= COMPARE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    COMPARE: begin
                        // Strict compare: ties keep the lower code.
                        if (acc > best_metric_q) begin
                            best_metric_q <= acc;
                            best_code_q   <= cur_code_q;
                        end
                        if (next_code_d[CODE_WIDTH]) begin
                            state_q <= APPLY;
                        end else begin
                            cur_code_q <= next_code_d[CODE_WIDTH-1:0];
                            del_code_q <= next_code_d[CODE_WIDTH-1:0];
                            state_q    <= SETTLE;
                        end
                    end
                    APPLY: begin
                        del_code_q <= best_code_q;
                        done_q     <= 1'b1;
                        locked_q   <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= TRACK;
                    end
                    TRACK: begin
                        del_code_q <= trk_code_d;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.del_code_o    = del_code_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.locked        = locked_q;
    assign bus.best_code_o   = best_code_q;
    assign bus.best_metric_o = best_metric_q;

endmodule

// File: tb/tb_rx_phase_sweep_ctrl.sv
// Directed + randomized bench for rx_phase_sweep_ctrl.
// The ADC is an eye profile indexed by the current delay code.
module tb_rx_phase_sweep_ctrl;
    import rx_ctrl_pkg::*;

    localparam int SWEEP_LAT = 1345;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    rx_phase_sweep_ctrl_if bus ();

    rx_phase_sweep_ctrl dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus.slave)
    );

    int nchecks = 0;
    int nerrors = 0;
    int mode    = 0;
    logic signed [7:0] tbl [64];

    function automatic logic signed [7:0] eye(input int m, input int code);
        int v;
        v = 0;
        case (m)
            0: v = 10;
            1: begin
                v = 100 - ((code > 100) ? code - 100 : 100 - code);
                if (v < 0) v = 0;
            end
            2: v = -128;
            3: v = code / 2;
            4: v = int'(tbl[code / 4]);
            default: v = 0;
        endcase
        return 8'(v);
    endfunction

    always_comb bus.adc_i = eye(mode, int'(bus.del_code_o));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: one dwell sums 16 equal magnitudes; first strict max wins.
    task automatic model_sweep(output int bc, output int bm);
        int s;
        int m;
        bc = 0;
        bm = 0;
        for (int c = 0; c <= 255; c += 4) begin
            s = int'(eye(mode, c));
            m = 16 * ((s < 0) ? -s : s);
            if (m > bm) begin
                bm = m;
                bc = c;
            end
        end
    endtask

    task automatic run_sweep(input string tag, input int hold);
        int n;
        int bc;
        int bm;
        model_sweep(bc, bm);
        bus.start = 1'b1;
        step();
        if (hold == 0) bus.start = 1'b0;
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_unlock"}, bus.locked, 0);
        n = 0;
        while (!bus.done && n < 3000) begin
            step();
            n++;
            if (n == hold) bus.start = 1'b0;
        end
        chk({tag, "_latency"}, n, SWEEP_LAT);
        chk({tag, "_best_code"}, bus.best_code_o, bc);
        chk({tag, "_best_metric"}, bus.best_metric_o, bm);
        chk({tag, "_del_code"}, bus.del_code_o, bc);
        chk({tag, "_locked"}, bus.locked, 1);
        chk({tag, "_busy_off"}, bus.busy, 0);
        step();
        chk({tag, "_done_pulse"}, bus.done, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_del"}, bus.del_code_o, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_locked"}, bus.locked, 0);
        chk({tag, "_bcode"}, bus.best_code_o, 0);
        chk({tag, "_bmetric"}, bus.best_metric_o, 0);
    endtask

    initial begin
        int exp_code;
        int pd;
        bit seen_done;

        bus.start    = 1'b1;
        bus.abort    = 1'b0;
        bus.pd_adj_i = 2'b00;

        rstb = 1'b0;
        repeat (3) step();
        chk_zero("rst");
        rstb      = 1'b1;
        bus.start = 1'b0;
        step();
        chk_zero("rst_rel");
        step();
        chk_zero("rst_idle");

        mode = 0;
        run_sweep("flat", 0);
        chk("flat_metric160", bus.best_metric_o, 160);
        chk("flat_code0", bus.best_code_o, 0);

        mode = 1;
        run_sweep("peak", 0);
        chk("peak_code100", bus.best_code_o, 100);
        chk("peak_metric1600", bus.best_metric_o, 1600);

        mode = 2;
        run_sweep("neg128", 0);
        chk("neg128_metric", bus.best_metric_o, 2048);

        mode = 3;
        run_sweep("ramp", 0);
        chk("ramp_code252", bus.best_code_o, 252);
        exp_code = int'(bus.del_code_o);
        bus.pd_adj_i = 2'b01;
        for (int i = 0; i < 10; i++) begin
            step();
            exp_code = (exp_code < 255) ? exp_code + 1 : 255;
            chk("trk_up", bus.del_code_o, exp_code);
        end
        bus.pd_adj_i = 2'b10;
        step();
        chk("trk_dn1", bus.del_code_o, 254);
        step();
        chk("trk_dn2", bus.del_code_o, 253);
        bus.pd_adj_i = 2'b00;
        step();
        chk("trk_hold", bus.del_code_o, 253);

        for (int r = 0; r < 3; r++) begin
            mode = 4;
            for (int i = 0; i < 64; i++) tbl[i] = 8'($urandom);
            run_sweep("rand", (r == 1) ? 40 : 0);
            exp_code = int'(bus.best_code_o);
            for (int i = 0; i < 150; i++) begin
                pd = int'($urandom_range(0, 3));
                bus.pd_adj_i = 2'(pd);
                step();
                if (pd == 1 && exp_code < 255) exp_code++;
                else if (pd >= 2 && exp_code > 0) exp_code--;
                chk("rand_trk", bus.del_code_o, exp_code);
            end
            bus.pd_adj_i = 2'b00;
        end

        mode = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("ab_restart_unlock", bus.locked, 0);
        repeat (49) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("ab_busy", bus.busy, 0);
        chk("ab_locked", bus.locked, 0);
        chk("ab_del", bus.del_code_o, 8);
        chk("ab_done", bus.done, 0);
        seen_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.done) seen_done = 1'b1;
        end
        chk("ab_no_done", 32'(seen_done), 0);
        chk("ab_idle_del", bus.del_code_o, 8);
        run_sweep("ab_rerun", 0);

        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (100) step();
        rstb = 1'b0;
        step();
        rstb = 1'b1;
        chk_zero("mid_rst");

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/rx_phase_sweep_ctrl.md
Name: rx_phase_sweep_ctrl

Overview:
Phase-acquisition controller for the receiver sampling clock. It owns the clk_delay code. On start it sweeps the delay code across its range and dwells at each step. During each dwell it accumulates ADC sample magnitude as an eye-opening metric, then applies the best code. It then hands off to bang-bang tracking driven by the mm_pd phase decision.

Parameters:
ADC_WIDTH, 8, signed ADC sample width
CODE_WIDTH, 8, delay code width (matches clk_delay)
CODE_STEP, 4, sweep increment between tested codes
DWELL_LOG2, 4, log2 of samples accumulated per code (16)
SETTLE_CYCLES, 4, cycles discarded after each code change (delay line + ADC latency)

Ports:
clk  input  1  receiver clock (clk_o domain)
rstb  input  1  synchronous active-low reset
start  input  1  begin (or restart) sweep; level sampled each cycle
abort  input  1  stop immediately and return to IDLE
adc_i  input  ADC_WIDTH  signed ADC sample
pd_adj_i  input  2  signed phase decision: +1 late, -1 early, 0 none
del_code_o  output  CODE_WIDTH  delay code to clk_delay
busy  output  1  sweep in progress
done  output  1  one-cycle pulse when sweep result applied
locked  output  1  in TRACK state
best_code_o  output  CODE_WIDTH  winning sweep code
best_metric_o  output  ADC_WIDTH+DWELL_LOG2  winning accumulated metric

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rstb); all state updates on the rising clk edge.
- Reset (rstb=0 at edge): state=IDLE; del_code_o=0, busy=0, done=0, locked=0, best_code_o=0, best_metric_o=0; counters and accumulator cleared.
- States: IDLE, SETTLE, ACCUM, COMPARE, APPLY, TRACK. busy=1 in SETTLE/ACCUM/COMPARE/APPLY only.
- IDLE: start=1 sets cur_code=0, del_code_o=0, best_code_o=0, best_metric_o=0, acc=0, then goes to SETTLE.
- SETTLE: stays exactly SETTLE_CYCLES cycles; adc_i is ignored; then goes to ACCUM.
- ACCUM: stays exactly 2^DWELL_LOG2 cycles. Each cycle acc += |adc_i|. The magnitude is sign-extended before negation, so |-128|=128. acc width is ADC_WIDTH+DWELL_LOG2 and cannot overflow (max 2048 < 4096). Then goes to COMPARE.
- COMPARE (1 cycle):
  - If acc > best_metric_o (strict), then best_metric_o=acc and best_code_o=cur_code. Ties keep the earlier, lower code.
  - acc is cleared.
  - If cur_code + CODE_STEP > 2^CODE_WIDTH-1, go to APPLY (no wrap-around).
  - Otherwise cur_code += CODE_STEP, del_code_o=new cur_code, and go to SETTLE.
- APPLY (1 cycle): del_code_o=best_code_o, done=1, locked=1 registered. Then goes to TRACK.
- TRACK: each cycle, pd_adj_i=+1 increments del_code_o and pd_adj_i=-1 or -2 decrements it. Both saturate at 0 and 2^CODE_WIDTH-1. 0 holds.
- Timing: N_codes = floor((2^CODE_WIDTH-1)/CODE_STEP)+1, which is 64 at defaults. From the edge that samples start, done rises after N_codes*(SETTLE_CYCLES+2^DWELL_LOG2+1)+1 cycles, which is 1345 at defaults.
- start during SETTLE/ACCUM/COMPARE/APPLY is ignored. start in TRACK clears locked and restarts the sweep exactly as from IDLE.
- abort has priority over start and over all transitions. Next state is IDLE with busy=0, locked=0, done=0. del_code_o holds its current value; best_* hold their values.
- Reset mid-operation behaves identically to power-on reset.
- done is never asserted on abort or reset.

Decomposition:
- Package rx_ctrl_pkg holds:
  - typedef enum logic [2:0] sweep_state_t {IDLE, SETTLE, ACCUM, COMPARE, APPLY, TRACK};
  - localparam helpers N_CODES and METRIC_WIDTH derived from the parameters.
- One sub-module, rx_abs_accum: signed input, clear, enable, unsigned accumulated output of METRIC_WIDTH.

Test Plan:
- Reset: hold rstb=0 for 3 cycles with start=1 -> all outputs 0, state IDLE; release with start=0 -> outputs remain 0.
- Flat eye: adc_i=+10 constant, pulse start -> every metric equals 160; best_code_o=0 (tie rule), best_metric_o=160; done high exactly one cycle, 1345 cycles after start; del_code_o=0; locked=1.
- Peaked eye: model adc_i = 100 - |del_code_o - 100|, clamped ≥0 -> best_code_o=100, best_metric_o=1600, del_code_o=100 after done.
- Extreme input: adc_i=-128 constant -> best_metric_o=2048 (no overflow), best_code_o=0.
- Tracking saturation: after lock at best_code 252, drive pd_adj_i=+1 for 10 cycles -> del_code_o 253, 254, 255, then holds at 255. Then drive pd_adj_i=-2 for 2 cycles -> 254, 253.
- Abort/restart: assert abort during ACCUM of the third code -> next cycle busy=0, locked=0, del_code_o=8, no done pulse. Then start -> full sweep repeats, and done arrives 1345 cycles later.
